// File: rtl/pid_cmd_controller.sv
// pid_cmd_controller
//   Takes 128-bit command frames from the UART receiver, checks the sync byte,
//   checksum and opcode, waits until the PID core is idle, then commits the
//   frame to the gain/setpoint/enable registers.
//
//   Optional build macro: PID_CMD_WATCHDOG_EN
//     Adds a watchdog that drops loop_en and sets a sticky timeout_flag once
//     the loop has run TIMEOUT_CYCLES cycles with no config traffic.
//
//   Ports
//     clk, reset      clock; synchronous active-low reset
//     frame_data      128-bit frame {sync, opcode, A, B, C, rsvd, checksum}
//     frame_valid     frame ready (level tolerated, rising edge = event)
//     pid_busy        PID core mid-computation, config must not change
//     kp/ki/kd        gain registers (COEF_W bits)
//     setpoint        loop setpoint (COEF_W bits)
//     loop_en         PID loop enable
//     cfg_update      one-cycle strobe, registers take new value at its end
//     frame_err       one-cycle pulse when a frame is rejected
//     err_count       rejected-frame count, saturates at 255
//     ctrl_busy       controller not in IDLE
//     timeout_flag    sticky watchdog trip (0 without the watchdog)
module pid_cmd_controller #(
    parameter int          COEF_W         = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 50000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [127:0]      frame_data,
    input  logic              frame_valid,
    input  logic              pid_busy,
    output logic [COEF_W-1:0] kp,
    output logic [COEF_W-1:0] ki,
    output logic [COEF_W-1:0] kd,
    output logic [COEF_W-1:0] setpoint,
    output logic              loop_en,
    output logic              cfg_update,
    output logic              frame_err,
    output logic [7:0]        err_count,
    output logic              ctrl_busy,
    output logic              timeout_flag
);

    typedef enum logic [1:0] {IDLE, CHECK, WAIT, APPLY} state_t;

    state_t            state_q, state_d;
    logic              fv_q;
    logic [127:0]      frame_q;
    logic [COEF_W-1:0] kp_q, kp_d, ki_q, ki_d, kd_q, kd_d, sp_q, sp_d;
    logic              loop_en_q, loop_en_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              frame_evt, apply, bad_frame, op_ok;
    logic [7:0]        cs_calc, opcode;

    assign frame_evt = frame_valid & ~fv_q;
    assign opcode    = frame_q[119:112];

    // Checksum covers bytes 15 (sync) down to 1 (reserved).
    always_comb begin
        cs_calc = 8'h00;
        for (int i = 1; i < 16; i++) cs_calc = cs_calc ^ frame_q[i*8 +: 8];
    end

    always_comb begin
        case (opcode)
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h11: op_ok = 1'b1;
            default:                                         op_ok = 1'b0;
        endcase
    end

    assign bad_frame = (frame_q[127:120] != SYNC_BYTE) || (cs_calc != frame_q[7:0]) || !op_ok;

`ifdef PID_CMD_WATCHDOG_EN
    logic [31:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;
    logic        wd_trip;
    // APPLY wins over a trip; a rejected frame clears the counter instead of
    // tripping so cfg_update and frame_err never coincide.
    assign wd_trip = loop_en_q && (wd_q == 32'(TIMEOUT_CYCLES - 1)) && !apply && !frame_err;
    assign cfg_update   = apply | wd_trip;
    assign timeout_flag = timeout_q;
`else
    assign cfg_update   = apply;
    assign timeout_flag = 1'b0;
`endif

    // Next-state and strobes
    always_comb begin
        state_d   = state_q;
        frame_err = 1'b0;
        apply     = 1'b0;
        case (state_q)
            IDLE:  if (frame_evt) state_d = CHECK;
            CHECK: begin
                if (bad_frame) begin
                    frame_err = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT:  if (!pid_busy) state_d = APPLY;
            APPLY: begin
                apply   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Config register next values
    always_comb begin
        kp_d      = kp_q;
        ki_d      = ki_q;
        kd_d      = kd_q;
        sp_d      = sp_q;
        loop_en_d = loop_en_q;
        err_cnt_d = err_cnt_q;
`ifdef PID_CMD_WATCHDOG_EN
        timeout_d = timeout_q;
        if (apply || frame_err || wd_trip) wd_d = 32'd0;
        else if (loop_en_q)                wd_d = wd_q + 32'd1;
        else                               wd_d = wd_q;
`endif
        if (frame_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        if (apply) begin
            case (opcode)
                8'h01: kp_d = frame_q[80 +: COEF_W];
                8'h02: ki_d = frame_q[80 +: COEF_W];
                8'h03: kd_d = frame_q[80 +: COEF_W];
                8'h04: sp_d = frame_q[80 +: COEF_W];
                8'h05: begin
                    kp_d = frame_q[80 +: COEF_W];
                    ki_d = frame_q[48 +: COEF_W];
                    kd_d = frame_q[16 +: COEF_W];
                end
                8'h10: begin
                    loop_en_d = 1'b1;
`ifdef PID_CMD_WATCHDOG_EN
                    timeout_d = 1'b0;
`endif
                end
                8'h11: loop_en_d = 1'b0;
                default: ;
            endcase
        end
`ifdef PID_CMD_WATCHDOG_EN
        else if (wd_trip) begin
            loop_en_d = 1'b0;
            timeout_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            fv_q      <= 1'b0;
            frame_q   <= '0;
            kp_q      <= '0;
            ki_q      <= '0;
            kd_q      <= '0;
            sp_q      <= '0;
            loop_en_q <= 1'b0;
            err_cnt_q <= 8'h00;
`ifdef PID_CMD_WATCHDOG_EN
            wd_q      <= 32'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            fv_q      <= frame_valid;
            if (state_q == IDLE && frame_evt) frame_q <= frame_data;
            kp_q      <= kp_d;
            ki_q      <= ki_d;
            kd_q      <= kd_d;
            sp_q      <= sp_d;
            loop_en_q <= loop_en_d;
            err_cnt_q <= err_cnt_d;
`ifdef PID_CMD_WATCHDOG_EN
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign kp        = kp_q;
    assign ki        = ki_q;
    assign kd        = kd_q;
    assign setpoint  = sp_q;
    assign loop_en   = loop_en_q;
    assign err_count = err_cnt_q;
    assign ctrl_busy = (state_q != IDLE);

endmodule

// File: tb/tb_pid_cmd_controller.sv
// Directed bench for pid_cmd_controller. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
module tb_pid_cmd_controller;

`ifdef PID_CMD_WATCHDOG_EN
    localparam int TO = 20;
`else
    localparam int TO = 50000000;
`endif

    // Frames with hand-computed XOR checksums
    localparam logic [127:0] F_GAINS = 128'hA5_05_00000123_00000045_00000067_00_A0;
    localparam logic [127:0] F_BADCS = 128'hA5_05_00000123_00000045_00000067_00_A1;
    localparam logic [127:0] F_SP    = 128'hA5_04_00000800_00000000_00000000_00_A9;
    localparam logic [127:0] F_KP55  = 128'hA5_01_00000055_00000000_00000000_00_F1;
    localparam logic [127:0] F_EN    = 128'hA5_10_00000000_00000000_00000000_00_B5;
    localparam logic [127:0] F_DIS   = 128'hA5_11_00000000_00000000_00000000_00_B4;
    localparam logic [127:0] F_KI    = 128'hA5_02_00001234_00000000_00000000_00_81;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [127:0] frame_data = '0;
    logic         frame_valid = 1'b0;
    logic         pid_busy = 1'b0;
    logic [15:0]  kp, ki, kd, setpoint;
    logic         loop_en, cfg_update, frame_err, ctrl_busy, timeout_flag;
    logic [7:0]   err_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pid_cmd_controller #(.COEF_W(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .frame_data(frame_data), .frame_valid(frame_valid),
        .pid_busy(pid_busy), .kp(kp), .ki(ki), .kd(kd), .setpoint(setpoint),
        .loop_en(loop_en), .cfg_update(cfg_update), .frame_err(frame_err),
        .err_count(err_count), .ctrl_busy(ctrl_busy), .timeout_flag(timeout_flag)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present a frame for one cycle; returns sampled in the CHECK cycle.
    task automatic send(input logic [127:0] f);
        frame_data  = f;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
    endtask

    initial begin
        int n;
        int upd;
        // reset
        step(); step();
        chk("rst_kp", 32'(kp), 0);
        chk("rst_sp", 32'(setpoint), 0);
        chk("rst_errcnt", 32'(err_count), 0);
        chk("rst_flags", {27'd0, loop_en, cfg_update, frame_err, ctrl_busy, timeout_flag}, 0);
        reset = 1'b1;
        step();

        // opcode 05: cfg_update on the third cycle after the event
        send(F_GAINS);
        chk("g_check", {30'd0, ctrl_busy, cfg_update}, 32'b10);
        chk("g_noerr", 32'(frame_err), 0);
        step();
        chk("g_wait_upd", 32'(cfg_update), 0);
        step();
        chk("g_apply_upd", 32'(cfg_update), 1);
        step();
        chk("g_kp", 32'(kp), 32'h0123);
        chk("g_ki", 32'(ki), 32'h0045);
        chk("g_kd", 32'(kd), 32'h0067);
        chk("g_sp", 32'(setpoint), 0);
        chk("g_idle", {30'd0, ctrl_busy, cfg_update}, 0);

        // bad checksum
        send(F_BADCS);
        chk("bad_err", {30'd0, frame_err, cfg_update}, 32'b10);
        step();
        chk("bad_cnt1", 32'(err_count), 1);
        chk("bad_kp", 32'(kp), 32'h0123);
        chk("bad_idle", {30'd0, ctrl_busy, frame_err}, 0);
        n = 0; upd = 0;
        for (int i = 0; i < 299; i++) begin
            frame_valid = 1'b1;
            step();
            n += int'(frame_err);
            upd += int'(cfg_update);
            frame_valid = 1'b0;
            step();
        end
        chk("bad_pulses", n, 299);
        chk("bad_noupd", upd, 0);
        chk("bad_sat", 32'(err_count), 255);

        // setpoint held off while PID busy
        pid_busy = 1'b1;
        send(F_SP);
        n = 0; upd = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            n += int'(ctrl_busy);
            upd += int'(cfg_update) + int'(setpoint != 16'h0);
        end
        chk("busy_ctrl", n, 9);
        chk("busy_hold", upd, 0);
        pid_busy = 1'b0;
        step();
        chk("busy_apply", {cfg_update, setpoint}, {1'b1, 16'h0000});
        step();
        chk("busy_sp", 32'(setpoint), 32'h0800);

        // second edge during WAIT and a long level are both ignored
        pid_busy = 1'b1;
        send(F_KP55);
        step();
        frame_valid = 1'b1;
        upd = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 3) pid_busy = 1'b0;
            step();
            upd += int'(cfg_update);
        end
        frame_valid = 1'b0;
        step();
        chk("lvl_one_upd", upd, 1);
        chk("lvl_kp", 32'(kp), 32'h0055);

        // enable loop, then reset during WAIT
        send(F_EN);
        step(); step(); step();
        chk("en_loop", 32'(loop_en), 1);
        pid_busy = 1'b1;
        send(F_DIS);
        step();
        chk("rw_wait", 32'(ctrl_busy), 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rw_regs", {kp, ki}, 0);
        chk("rw_sp_cnt", {8'd0, setpoint, err_count}, 0);
        chk("rw_flags", {27'd0, loop_en, cfg_update, frame_err, ctrl_busy, timeout_flag}, 0);
        pid_busy = 1'b0;
        upd = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            upd += int'(cfg_update);
        end
        chk("rw_noupd", upd, 0);

        // normal operation after reset
        send(F_KI);
        step(); step(); step();
        chk("post_ki", {kp, ki}, {16'h0000, 16'h1234});

`ifdef PID_CMD_WATCHDOG_EN
        send(F_EN);
        step(); step();
        chk("wd_apply", 32'(cfg_update), 1);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (!loop_en) break;
            n++;
        end
        chk("wd_len", n, 20);
        chk("wd_flag", 32'(timeout_flag), 1);
        send(F_EN);
        step(); step(); step();
        chk("wd_clear", {timeout_flag, loop_en}, 32'b01);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
